// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared widths and lane helpers for the ordered read-data dispatcher
package dsp_pkg;

   // Width of one buffered R beat: {id, data, resp, last}
   function automatic int data_info_w(input int id_w, input int data_w, input int resp_w);
      return id_w + data_w + resp_w + 1;
   endfunction

   // Width of one order-queue entry: {slave index, arlen}
   function automatic int ord_info_w(input int slv_id_w, input int arlen_w);
      return slv_id_w + arlen_w;
   endfunction

   // LSB of lane 'lane' inside a packed per-slave bus of lanes 'lane_w' wide
   function automatic int lane_lsb(input int lane, input int lane_w);
      return lane * lane_w;
   endfunction

endpackage

// File: rtl/dsp_sync_fifo.sv
// rtl/dsp_sync_fifo.sv - show-ahead synchronous FIFO, power-of-2 depth, sync active-high reset
module dsp_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // storage write; contents only become visible once the write pointer passes them
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // pointers carry one wrap bit so full and empty are distinguishable
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/dsp_rdata_ordered_channel.sv
// rtl/dsp_rdata_ordered_channel.sv - in-order R dispatcher per master; DSP_RDATA_BEAT_CHECK_EN adds beat counting
module dsp_rdata_ordered_channel
   import dsp_pkg::*;
#(
   parameter int SLV_AMT         = 4,
   parameter int DATA_WIDTH      = 64,
   parameter int TRANS_MST_ID_W  = 5,
   parameter int TRANS_RESP_W    = 2,
   parameter int SLV_ID_W        = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1,
   parameter int DSP_RDATA_DEPTH = 16,
   parameter int DSP_ORD_DEPTH   = 8,
   parameter int ARLEN_W         = 8
) (
   input  logic                                ACLK_i,
   input  logic                                ARESET_i,
   input  logic [SLV_ID_W-1:0]                 dsp_AR_slv_id_i,
   input  logic [ARLEN_W-1:0]                  dsp_AR_len_i,
   input  logic                                dsp_AR_valid_i,
   output logic                                dsp_AR_ready_o,
   input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]   sa_RID_i,
   input  logic [DATA_WIDTH*SLV_AMT-1:0]       sa_RDATA_i,
   input  logic [TRANS_RESP_W*SLV_AMT-1:0]     sa_RRESP_i,
   input  logic [SLV_AMT-1:0]                  sa_RLAST_i,
   input  logic [SLV_AMT-1:0]                  sa_RVALID_i,
   output logic [SLV_AMT-1:0]                  sa_RREADY_o,
   output logic [TRANS_MST_ID_W-1:0]           m_RID_o,
   output logic [DATA_WIDTH-1:0]               m_RDATA_o,
   output logic [TRANS_RESP_W-1:0]             m_RRESP_o,
   output logic                                m_RLAST_o,
   output logic                                m_RVALID_o,
   input  logic                                m_RREADY_i,
   output logic [$clog2(DSP_ORD_DEPTH):0]      dsp_outstanding_o,
   output logic                                dsp_err_o
);
   localparam int DW  = data_info_w(TRANS_MST_ID_W, DATA_WIDTH, TRANS_RESP_W);
   localparam int OW  = ord_info_w(SLV_ID_W, ARLEN_W);
   localparam int RCW = $clog2(DSP_RDATA_DEPTH) + 1;
   localparam int OCW = $clog2(DSP_ORD_DEPTH) + 1;

   logic [DW-1:0]      slv_in    [SLV_AMT];
   logic [DW-1:0]      slv_head  [SLV_AMT];
   logic [RCW-1:0]     slv_cnt   [SLV_AMT];
   logic [SLV_AMT-1:0] slv_full;
   logic [SLV_AMT-1:0] slv_empty;
   logic [SLV_AMT-1:0] slv_push;
   logic [SLV_AMT-1:0] slv_pop;

   logic [OW-1:0]       ord_head;
   logic [OCW-1:0]      ord_cnt;
   logic                ord_empty;
   logic                ord_full;
   logic                ord_push;
   logic                ord_pop;
   logic [SLV_ID_W-1:0] head_slv;
   logic [ARLEN_W-1:0]  head_len;

   logic          sel_empty;
   logic [DW-1:0] sel_beat;
   logic          last_eff;
   logic          fwd_valid;
   logic          move;
   logic [DW-1:0] fwd_beat;

   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          skid_valid;
   logic [DW-1:0] skid_data;
   logic          skid_ready;

   // ---- per-slave beat buffers ----
   for (genvar s = 0; s < SLV_AMT; s++) begin : g_slv
      assign slv_in[s] = {sa_RID_i[lane_lsb(s, TRANS_MST_ID_W) +: TRANS_MST_ID_W],
                          sa_RDATA_i[lane_lsb(s, DATA_WIDTH) +: DATA_WIDTH],
                          sa_RRESP_i[lane_lsb(s, TRANS_RESP_W) +: TRANS_RESP_W],
                          sa_RLAST_i[s]};
      assign slv_full[s]  = (slv_cnt[s] == RCW'(DSP_RDATA_DEPTH));
      assign slv_empty[s] = (slv_cnt[s] == '0);
      assign slv_push[s]  = sa_RVALID_i[s] & ~slv_full[s];
      assign slv_pop[s]   = move & (head_slv == SLV_ID_W'(s));

      dsp_sync_fifo #(.WIDTH(DW), .DEPTH(DSP_RDATA_DEPTH)) u_rdata_fifo (
         .clk       (ACLK_i),
         .rst       (ARESET_i),
         .push      (slv_push[s]),
         .push_data (slv_in[s]),
         .pop       (slv_pop[s]),
         .head      (slv_head[s]),
         .count     (slv_cnt[s])
      );
   end

   assign sa_RREADY_o = ~slv_full;

   // ---- order queue: one entry per issued AR, retired on the last beat moved ----
   assign ord_empty      = (ord_cnt == '0);
   assign ord_full       = (ord_cnt == OCW'(DSP_ORD_DEPTH));
   assign dsp_AR_ready_o = ~ord_full | ord_pop;
   assign ord_push       = dsp_AR_valid_i & dsp_AR_ready_o;
   assign ord_pop        = move & last_eff;
   assign head_slv       = ord_head[OW-1 -: SLV_ID_W];
   assign head_len       = ord_head[ARLEN_W-1:0];
   assign dsp_outstanding_o = ord_cnt;

   dsp_sync_fifo #(.WIDTH(OW), .DEPTH(DSP_ORD_DEPTH)) u_ord_fifo (
      .clk       (ACLK_i),
      .rst       (ARESET_i),
      .push      (ord_push),
      .push_data ({dsp_AR_slv_id_i, dsp_AR_len_i}),
      .pop       (ord_pop),
      .head      (ord_head),
      .count     (ord_cnt)
   );

   // select the beat buffer named by the head order entry
   always_comb begin
      sel_empty = 1'b1;
      sel_beat  = '0;
      for (int s = 0; s < SLV_AMT; s++) begin
         if (head_slv == SLV_ID_W'(s)) begin
            sel_empty = slv_empty[s];
            sel_beat  = slv_head[s];
         end
      end
   end

   assign fwd_valid = ~ord_empty & ~sel_empty;
   assign move      = fwd_valid & skid_ready;
   assign fwd_beat  = {sel_beat[DW-1:1], last_eff};

`ifdef DSP_RDATA_BEAT_CHECK_EN
   logic [ARLEN_W:0] beat_cnt;
   logic             err_q;
   logic             len_hit;

   assign len_hit   = (beat_cnt == {1'b0, head_len});
   assign last_eff  = sel_beat[0] | len_hit;
   assign dsp_err_o = err_q;

   // count beats of the head burst; any RLAST/ARLEN disagreement latches the error
   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         beat_cnt <= '0;
         err_q    <= 1'b0;
      end else if (move) begin
         beat_cnt <= last_eff ? '0 : beat_cnt + (ARLEN_W+1)'(1);
         if (sel_beat[0] != len_hit) err_q <= 1'b1;
      end
   end
`else
   assign last_eff  = sel_beat[0];
   assign dsp_err_o = 1'b0;
`endif

   // ---- 2-entry skid: registered outputs, upstream ready depends only on skid state ----
   assign skid_ready = ~skid_valid;

   // output register refills from the skid first, otherwise straight from the forward path
   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (~out_valid | m_RREADY_i) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= move;
            if (move) out_data <= fwd_beat;
         end
      end else if (move) begin
         skid_valid <= 1'b1;
         skid_data  <= fwd_beat;
      end
   end

   assign m_RVALID_o = out_valid;
   assign m_RLAST_o  = out_data[0];
   assign m_RRESP_o  = out_data[TRANS_RESP_W:1];
   assign m_RDATA_o  = out_data[TRANS_RESP_W+1 +: DATA_WIDTH];
   assign m_RID_o    = out_data[TRANS_RESP_W+1+DATA_WIDTH +: TRANS_MST_ID_W];

endmodule
